// File: rtl/unidad_carga_almacenamiento_pkg.sv
// Shared types and constants for the load/store unit.
package unidad_carga_almacenamiento_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DEPTH_WORDS_DEF = 32;

  // Request access width encodings
  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  // One-hot controller states
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_LOAD   = 6'b000010,
    ST_STORE  = 6'b000100,
    ST_RMW_RD = 6'b001000,
    ST_RMW_WR = 6'b010000,
    ST_RESP   = 6'b100000
  } state_e;

  // Access attributes kept for the duration of a request
  typedef struct packed {
    size_e      size;
    logic       sgn;
    logic [1:0] off;
  } lsu_ctl_t;

  // Misaligned, out-of-range or reserved-size request
  function automatic logic req_error(input size_e size,
                                     input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] limit);
    logic err;
    err = (addr >= limit);
    case (size)
      SIZE_H:   err = err | addr[0];
      SIZE_W:   err = err | (addr[1:0] != 2'b00);
      SIZE_RSV: err = 1'b1;
      default:  err = err;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/unidad_carga_almacenamiento_if.sv
// Request/response and data-memory signals of the load/store unit.
interface unidad_carga_almacenamiento_if;
  import unidad_carga_almacenamiento_pkg::*;

  logic              Req_Valid;
  logic              Req_Ready;
  logic              Req_Write;
  logic [1:0]        Req_Size;
  logic              Req_Signed;
  logic [ADDR_W-1:0] Req_Addr;
  logic [DATA_W-1:0] Req_WData;
  logic              Resp_Valid;
  logic [DATA_W-1:0] Resp_RData;
  logic              Resp_Error;
  logic [ADDR_W-1:0] Mem_Address;
  logic [DATA_W-1:0] Mem_Write_Data;
  logic              Mem_MemWrite;
  logic              Mem_MemRead;
  logic [DATA_W-1:0] Mem_Read_Data;

  // Load/store unit side
  modport slave (
    input  Req_Valid, Req_Write, Req_Size, Req_Signed, Req_Addr, Req_WData,
    input  Mem_Read_Data,
    output Req_Ready, Resp_Valid, Resp_RData, Resp_Error,
    output Mem_Address, Mem_Write_Data, Mem_MemWrite, Mem_MemRead
  );

  // Pipeline and memory side
  modport master (
    output Req_Valid, Req_Write, Req_Size, Req_Signed, Req_Addr, Req_WData,
    output Mem_Read_Data,
    input  Req_Ready, Resp_Valid, Resp_RData, Resp_Error,
    input  Mem_Address, Mem_Write_Data, Mem_MemWrite, Mem_MemRead
  );

endinterface

// File: rtl/unidad_carga_almacenamiento_alineador_datos.sv
// Lane steering: load extract/extend and store read-modify-write merge.
module alineador_datos
  import unidad_carga_almacenamiento_pkg::*;
(
  input  size_e             size_i,
  input  logic              signed_i,
  input  logic [1:0]        offset_i,
  input  logic [DATA_W-1:0] rd_word_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic [DATA_W-1:0] ld_data_c_o,
  output logic [DATA_W-1:0] mrg_word_c_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Select the addressed lane (little-endian) and build both results
  always_comb begin
    lane_b       = 8'h00;
    lane_h       = 16'h0000;
    ld_data_c_o  = rd_word_i;
    mrg_word_c_o = rd_word_i;

    case (offset_i)
      2'd0:    lane_b = rd_word_i[7:0];
      2'd1:    lane_b = rd_word_i[15:8];
      2'd2:    lane_b = rd_word_i[23:16];
      default: lane_b = rd_word_i[31:24];
    endcase
    lane_h = offset_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

    case (size_i)
      SIZE_B: begin
        ld_data_c_o = signed_i ? {{24{lane_b[7]}}, lane_b} : {24'h000000, lane_b};
        case (offset_i)
          2'd0:    mrg_word_c_o[7:0]   = st_data_i[7:0];
          2'd1:    mrg_word_c_o[15:8]  = st_data_i[7:0];
          2'd2:    mrg_word_c_o[23:16] = st_data_i[7:0];
          default: mrg_word_c_o[31:24] = st_data_i[7:0];
        endcase
      end
      SIZE_H: begin
        ld_data_c_o = signed_i ? {{16{lane_h[15]}}, lane_h} : {16'h0000, lane_h};
        if (offset_i[1]) mrg_word_c_o[31:16] = st_data_i[15:0];
        else             mrg_word_c_o[15:0]  = st_data_i[15:0];
      end
      default: begin
        ld_data_c_o  = rd_word_i;
        mrg_word_c_o = st_data_i;
      end
    endcase
  end

endmodule

// File: rtl/unidad_carga_almacenamiento.sv
// Load/store unit in front of a word-addressed data memory.
module unidad_carga_almacenamiento
  import unidad_carga_almacenamiento_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic Clk,
  input  logic Reset_n,
  unidad_carga_almacenamiento_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * DEPTH_WORDS);

  state_e            state_q;
  lsu_ctl_t          ctl_q;
  logic              ready_q;
  logic              resp_valid_q;
  logic              resp_error_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept_c;
  logic              err_c;
  size_e             req_size_c;
  logic [DATA_W-1:0] ld_data_c;
  logic [DATA_W-1:0] mrg_word_c;

  assign req_size_c = size_e'(bus.Req_Size);
  assign accept_c   = bus.Req_Valid & ready_q;
  assign err_c      = req_error(req_size_c, bus.Req_Addr, ADDR_LIMIT);

  // Lane steering on the registered request against live memory data
  alineador_datos u_alineador (
    .size_i       (ctl_q.size),
    .signed_i     (ctl_q.sgn),
    .offset_i     (ctl_q.off),
    .rd_word_i    (bus.Mem_Read_Data),
    .st_data_i    (wdata_q),
    .ld_data_c_o  (ld_data_c),
    .mrg_word_c_o (mrg_word_c)
  );

  // Controller: state, memory strobes and response all come straight from flops
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      ctl_q        <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
    end else begin
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept_c) begin
            ready_q    <= 1'b0;
            ctl_q.size <= req_size_c;
            ctl_q.sgn  <= bus.Req_Signed;
            ctl_q.off  <= bus.Req_Addr[1:0];
            mem_addr_q <= {2'b00, bus.Req_Addr[ADDR_W-1:2]};
            wdata_q    <= bus.Req_WData;
            if (err_c) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
            end else if (!bus.Req_Write) begin
              state_q  <= ST_LOAD;
              mem_rd_q <= 1'b1;
            end else if (req_size_c == SIZE_W) begin
              state_q  <= ST_STORE;
              mem_wr_q <= 1'b1;
            end else begin
              state_q  <= ST_RMW_RD;
              mem_rd_q <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          rdata_q      <= ld_data_c;
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
        end

        ST_STORE: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
        end

        // Old word and new lane are merged as the read completes
        ST_RMW_RD: begin
          wdata_q  <= mrg_word_c;
          state_q  <= ST_RMW_WR;
          mem_wr_q <= 1'b1;
        end

        ST_RMW_WR: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Req_Ready      = ready_q;
  assign bus.Resp_Valid     = resp_valid_q;
  assign bus.Resp_Error     = resp_error_q;
  assign bus.Resp_RData     = rdata_q;
  assign bus.Mem_Address    = mem_addr_q;
  assign bus.Mem_Write_Data = wdata_q;
  assign bus.Mem_MemRead    = mem_rd_q;
  assign bus.Mem_MemWrite   = mem_wr_q;

endmodule

// File: tb/tb_unidad_carga_almacenamiento.sv
// Directed scoreboard bench for the load/store unit with a 32-word memory model.
module tb_unidad_carga_almacenamiento;
  import unidad_carga_almacenamiento_pkg::*;

  typedef struct {
    string       tag;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic        chk_wdata;
    logic [31:0] wdata;
    logic [31:0] waddr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unidad_carga_almacenamiento_if bus_if ();

  unidad_carga_almacenamiento #(.DEPTH_WORDS(32)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus_if)
  );

  // Memory model: combinational read, write on rising edge while enabled
  logic [31:0] mem [0:31];
  logic        mem_init_done = 1'b0;
  assign bus_if.Mem_Read_Data = (bus_if.Mem_Address < 32'd32) ? mem[bus_if.Mem_Address[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 1) ? 32'h80818283 : 32'h0;
      mem_init_done <= 1'b1;
    end else if (bus_if.Mem_MemWrite && bus_if.Mem_Address < 32'd32) begin
      mem[bus_if.Mem_Address[4:0]] <= bus_if.Mem_Write_Data;
    end
  end

  // Strobe activity monitor
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] wr_data_seen = 32'h0;
  logic [31:0] addr_seen = 32'h0;
  always @(negedge clk) begin
    if (bus_if.Mem_MemRead) rd_cnt++;
    if (bus_if.Mem_MemWrite) begin
      wr_cnt++;
      wr_data_seen = bus_if.Mem_Write_Data;
      addr_seen    = bus_if.Mem_Address;
    end
    if (bus_if.Mem_MemRead && bus_if.Mem_MemWrite) both_cnt++;
  end

  int   checks = 0;
  int   errors = 0;
  int   rd_base = 0;
  int   wr_base = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic cr, input logic [31:0] rd,
                              input logic err, input int lat, input int nrd, input int nwr,
                              input logic cw, input logic [31:0] wd, input logic [31:0] wa);
    exp_t e;
    e.tag = tag; e.chk_rdata = cr; e.rdata = rd; e.err = err; e.lat = lat;
    e.nrd = nrd; e.nwr = nwr; e.chk_wdata = cw; e.wdata = wd; e.waddr = wa;
    return e;
  endfunction

  // Present a request (caller sits at a falling edge) and wait for its accept edge
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input exp_t e);
    bit acc;
    sb.push_back(e);
    bus_if.Req_Valid  = 1'b1;
    bus_if.Req_Write  = w;
    bus_if.Req_Size   = sz;
    bus_if.Req_Signed = sg;
    bus_if.Req_Addr   = a;
    bus_if.Req_WData  = wd;
    acc = 1'b0;
    for (int n = 0; n < 20; n++) begin
      acc = bus_if.Req_Ready;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    chk({e.tag, "_accept"}, 32'(acc), 32'd1);
    rd_base = rd_cnt;
    wr_base = wr_cnt;
  endtask

  // Wait for the response pulse and score it against the oldest expectation
  task automatic collect();
    exp_t        e;
    int          lat;
    bit          got;
    logic [31:0] rdata;
    logic        err;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    lat = 0; got = 1'b0; rdata = 32'h0; err = 1'b0;
    while (lat < 10 && !got) begin
      @(negedge clk);
      if (lat == 0) bus_if.Req_Valid = 1'b0;
      lat++;
      got = bus_if.Resp_Valid;
    end
    rdata = bus_if.Resp_RData;
    err   = bus_if.Resp_Error;
    chk({e.tag, "_resp"}, 32'(got), 32'd1);
    chk({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({e.tag, "_err"}, 32'(err), 32'(e.err));
    if (e.chk_rdata) chk({e.tag, "_rdata"}, rdata, e.rdata);
    @(negedge clk);
    chk({e.tag, "_pulse"}, 32'(bus_if.Resp_Valid), 32'd0);
    chk({e.tag, "_nrd"}, 32'(rd_cnt - rd_base), 32'(e.nrd));
    chk({e.tag, "_nwr"}, 32'(wr_cnt - wr_base), 32'(e.nwr));
    if (e.chk_wdata) begin
      chk({e.tag, "_wdata"}, wr_data_seen, e.wdata);
      chk({e.tag, "_waddr"}, addr_seen, e.waddr);
    end
  endtask

  task automatic req(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input exp_t e);
    issue(w, sz, sg, a, wd, e);
    collect();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({bus_if.Req_Ready, bus_if.Resp_Valid, bus_if.Resp_Error,
                            bus_if.Mem_MemRead, bus_if.Mem_MemWrite}), 32'd0);
    chk({tag, "_rdata"}, bus_if.Resp_RData, 32'h0);
    chk({tag, "_addr"}, bus_if.Mem_Address, 32'h0);
    chk({tag, "_wdata"}, bus_if.Mem_Write_Data, 32'h0);
  endtask

  initial begin
    exp_t e;
    bus_if.Req_Valid  = 1'b0;
    bus_if.Req_Write  = 1'b0;
    bus_if.Req_Size   = 2'b00;
    bus_if.Req_Signed = 1'b0;
    bus_if.Req_Addr   = 32'h0;
    bus_if.Req_WData  = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", 32'(bus_if.Req_Ready), 32'd1);

    // Loads from the preloaded word 0x80818283
    req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, mk("lw4",  1'b1, 32'h80818283, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));
    req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, mk("lb7s", 1'b1, 32'hFFFFFF80, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));
    req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, mk("lbu7", 1'b1, 32'h00000080, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));
    req(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, mk("lh4s", 1'b1, 32'hFFFF8283, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));
    req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, mk("lhu6", 1'b1, 32'h00008081, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));
    req(1'b0, 2'b00, 1'b1, 32'h4, 32'h0, mk("lb4s", 1'b1, 32'hFFFFFF83, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));
    req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, mk("lbu5", 1'b1, 32'h00000082, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));

    // Sub-word stores through read-modify-write
    req(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000AB, mk("sb5", 1'b0, 32'h0, 1'b0, 3, 1, 1, 1'b1, 32'h8081AB83, 32'h1));
    req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, mk("lw4_sb", 1'b1, 32'h8081AB83, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));
    req(1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF1234, mk("sh6", 1'b0, 32'h0, 1'b0, 3, 1, 1, 1'b1, 32'h1234AB83, 32'h1));
    req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, mk("lw4_sh", 1'b1, 32'h1234AB83, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));

    // Error requests: no memory access, response one cycle after accept
    req(1'b1, 2'b10, 1'b0, 32'h6,  32'h11111111, mk("e_sw6",   1'b0, 32'h0, 1'b1, 1, 0, 0, 1'b0, 32'h0, 32'h0));
    req(1'b0, 2'b01, 1'b1, 32'h3,  32'h0,        mk("e_lh3",   1'b0, 32'h0, 1'b1, 1, 0, 0, 1'b0, 32'h0, 32'h0));
    req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        mk("e_lw80",  1'b0, 32'h0, 1'b1, 1, 0, 0, 1'b0, 32'h0, 32'h0));
    req(1'b0, 2'b11, 1'b0, 32'h4,  32'h0,        mk("e_size3", 1'b0, 32'h0, 1'b1, 1, 0, 0, 1'b0, 32'h0, 32'h0));
    req(1'b1, 2'b00, 1'b0, 32'h80, 32'h000000EE, mk("e_sb80",  1'b0, 32'h0, 1'b1, 1, 0, 0, 1'b0, 32'h0, 32'h0));
    chk("mem1_after_errors", mem[1], 32'h1234AB83);

    // Last valid word
    req(1'b1, 2'b10, 1'b0, 32'h7C, 32'hDEADBEEF, mk("sw7c", 1'b0, 32'h0, 1'b0, 2, 0, 1, 1'b1, 32'hDEADBEEF, 32'h1F));
    req(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, mk("lw7c",  1'b1, 32'hDEADBEEF, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));
    req(1'b0, 2'b00, 1'b0, 32'h7F, 32'h0, mk("lbu7f", 1'b1, 32'h000000DE, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));

    // Req_Valid held across SW then LW to the same word
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, mk("b2b_sw", 1'b0, 32'h0, 1'b0, 2, 0, 1, 1'b0, 32'h0, 32'h0));
    @(negedge clk);
    bus_if.Req_Write = 1'b0;
    bus_if.Req_WData = 32'h0;
    chk("b2b_ready_store", 32'(bus_if.Req_Ready), 32'd0);
    @(negedge clk);
    chk("b2b_ready_resp", 32'(bus_if.Req_Ready), 32'd0);
    e = sb.pop_front();
    chk("b2b_sw_resp", 32'(bus_if.Resp_Valid), 32'd1);
    chk("b2b_sw_err", 32'(bus_if.Resp_Error), 32'(e.err));
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, mk("b2b_lw", 1'b1, 32'hCAFEF00D, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));
    collect();
    chk("b2b_mem4", mem[4], 32'hCAFEF00D);

    // Asynchronous reset in the middle of a read-modify-write
    bus_if.Req_Valid  = 1'b1;
    bus_if.Req_Write  = 1'b1;
    bus_if.Req_Size   = 2'b00;
    bus_if.Req_Signed = 1'b0;
    bus_if.Req_Addr   = 32'h4;
    bus_if.Req_WData  = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    chk("rst_rmw_rd_active", 32'(bus_if.Mem_MemRead), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    bus_if.Req_Valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready_after", 32'(bus_if.Req_Ready), 32'd1);
    chk("rst_mem1_unchanged", mem[1], 32'h1234AB83);
    req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, mk("lw4_rst", 1'b1, 32'h1234AB83, 1'b0, 2, 1, 0, 1'b0, 32'h0, 32'h0));

    chk("never_both_enables", 32'(both_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
